// File: rtl/bit_serializer_pkg.sv
// Shared types and constants for the bit serializer.
// The MSB-first option is selected with the SER_MSB_FIRST_EN macro in bit_serializer.sv.
package bit_ser_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int unsigned DATA_W_DEF = 8;

    function automatic int unsigned cnt_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Parallel-word handshake in, framed serial bit stream out.
// The master modport is the word source; the slave modport is the serializer.
interface bit_serializer_if #(
    parameter int unsigned DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              data;
    logic              data_start;
    logic              data_finish;
    logic              busy;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  data,
        input  data_start,
        input  data_finish,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output data,
        output data_start,
        output data_finish,
        output busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Serialises one parallel word per frame, one bit per clock, with start/finish strobes.
// Define SER_MSB_FIRST_EN for MSB-first order; the default is LSB first.
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic        clk,
    input  logic        rst,
    bit_serializer_if.slave bus
);

    localparam int unsigned CntW = cnt_w(DATA_W);
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CntW-1:0]   cnt_q;
    logic              data_q;
    logic              start_q;
    logic              finish_q;
    logic              busy_q;

    logic              last_bit;
    logic              in_ready;
    logic              accept;
    logic [CntW-1:0]   cnt_inc;
    logic              load_bit;
    logic [DATA_W-1:0] load_rest;
    logic              next_bit;
    logic [DATA_W-1:0] next_rest;

    always_comb begin
        last_bit = (cnt_q == CntLast);
        in_ready = (state_q == IDLE) || ((state_q == SHIFT) && last_bit);
        accept   = bus.in_valid && in_ready;
        cnt_inc  = cnt_q + CntW'(1);
`ifdef SER_MSB_FIRST_EN
        load_bit  = bus.in_data[DATA_W-1];
        load_rest = bus.in_data << 1;
        next_bit  = shift_q[DATA_W-1];
        next_rest = shift_q << 1;
`else
        load_bit  = bus.in_data[0];
        load_rest = bus.in_data >> 1;
        next_bit  = shift_q[0];
        next_rest = shift_q >> 1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            data_q   <= 1'b0;
            start_q  <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else if (accept) begin
            // New frame, either from idle or back-to-back on the last bit.
            state_q  <= SHIFT;
            shift_q  <= load_rest;
            cnt_q    <= '0;
            data_q   <= load_bit;
            start_q  <= 1'b1;
            finish_q <= (CntLast == '0);
            busy_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    data_q   <= 1'b0;
                    start_q  <= 1'b0;
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                SHIFT: begin
                    start_q <= 1'b0;
                    if (last_bit) begin
                        state_q  <= IDLE;
                        shift_q  <= '0;
                        cnt_q    <= '0;
                        data_q   <= 1'b0;
                        finish_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else begin
                        shift_q  <= next_rest;
                        cnt_q    <= cnt_inc;
                        data_q   <= next_bit;
                        finish_q <= (cnt_inc == CntLast);
                        busy_q   <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.data        = data_q;
    assign bus.data_start  = start_q;
    assign bus.data_finish = finish_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer at DATA_W=8 and DATA_W=1.
// Expected bit orders follow SER_MSB_FIRST_EN when it is defined.
module tb_bit_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bit_serializer_if #(.DATA_W(8)) bus8 ();
    bit_serializer_if #(.DATA_W(1)) bus1 ();

    bit_serializer #(.DATA_W(8)) u_dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    bit_serializer #(.DATA_W(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // Expected line bit for cycle i of a frame is seq[i].
`ifdef SER_MSB_FIRST_EN
    localparam logic [7:0] Seq129 = 8'b1000_0001;
    localparam logic [7:0] Seq17  = 8'b1000_1000;
    localparam logic [7:0] Seq1   = 8'b1000_0000;
    localparam logic [7:0] Seq136 = 8'b0001_0001;
`else
    localparam logic [7:0] Seq129 = 8'b1000_0001;
    localparam logic [7:0] Seq17  = 8'b0001_0001;
    localparam logic [7:0] Seq1   = 8'b0000_0001;
    localparam logic [7:0] Seq136 = 8'b1000_1000;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle8(input string tag);
        check({tag, ".data"}, 32'(bus8.data), 32'd0);
        check({tag, ".start"}, 32'(bus8.data_start), 32'd0);
        check({tag, ".finish"}, 32'(bus8.data_finish), 32'd0);
        check({tag, ".busy"}, 32'(bus8.busy), 32'd0);
        check({tag, ".ready"}, 32'(bus8.in_ready), 32'd1);
    endtask

    // Checks one 8-bit frame already on the line; drops in_valid after the first bit.
    task automatic check_frame8(input string tag, input logic [7:0] seq);
        logic [7:0] s;
        s = seq;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s.data%0d", tag, i), 32'(bus8.data), 32'(s[i]));
            check($sformatf("%s.start%0d", tag, i), 32'(bus8.data_start), 32'(i == 0));
            check($sformatf("%s.finish%0d", tag, i), 32'(bus8.data_finish), 32'(i == 7));
            check($sformatf("%s.busy%0d", tag, i), 32'(bus8.busy), 32'd1);
            check($sformatf("%s.ready%0d", tag, i), 32'(bus8.in_ready), 32'(i == 7));
            bus8.in_valid = 1'b0;
            tick();
        end
    endtask

    initial begin
        logic [7:0] s;
        bus8.in_valid = 1'b0;
        bus8.in_data  = '0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = '0;

        // Reset held 3 cycles.
        repeat (3) tick();
        rst = 1'b0;
        check_idle8("reset");
        check("reset.dw1_busy", 32'(bus1.busy), 32'd0);
        check("reset.dw1_ready", 32'(bus1.in_ready), 32'd1);
        tick();
        check_idle8("post_reset");

        // Single word 129.
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'd129;
        tick();
        check_frame8("w129", Seq129);
        check_idle8("w129_after");

        // Back-to-back 17 then 1 with in_valid held.
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'd17;
        tick();
        bus8.in_data = 8'd1;
        for (int i = 0; i < 16; i++) begin
            s = (i < 8) ? Seq17 : Seq1;
            check($sformatf("b2b.data%0d", i), 32'(bus8.data), 32'(s[i % 8]));
            check($sformatf("b2b.start%0d", i), 32'(bus8.data_start), 32'((i % 8) == 0));
            check($sformatf("b2b.finish%0d", i), 32'(bus8.data_finish), 32'((i % 8) == 7));
            check($sformatf("b2b.busy%0d", i), 32'(bus8.busy), 32'd1);
            check($sformatf("b2b.ready%0d", i), 32'(bus8.in_ready), 32'((i % 8) == 7));
            if (i == 8) bus8.in_valid = 1'b0;
            tick();
        end
        check_idle8("b2b_after");

        // Reset in the middle of a frame of 17.
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'd17;
        tick();
        bus8.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort.data%0d", i), 32'(bus8.data), 32'(Seq17[i]));
            if (i < 2) tick();
        end
        rst = 1'b1;
        tick();
        check("abort.rst_data", 32'(bus8.data), 32'd0);
        check("abort.rst_start", 32'(bus8.data_start), 32'd0);
        check("abort.rst_finish", 32'(bus8.data_finish), 32'd0);
        check("abort.rst_busy", 32'(bus8.busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort.no_finish%0d", i), 32'(bus8.data_finish), 32'd0);
            check($sformatf("abort.idle_busy%0d", i), 32'(bus8.busy), 32'd0);
            tick();
        end
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'd136;
        tick();
        check_frame8("w136", Seq136);
        check_idle8("w136_after");

        // DATA_W=1: send 1 then 0 back-to-back.
        bus1.in_valid = 1'b1;
        bus1.in_data  = 1'b1;
        tick();
        bus1.in_data = 1'b0;
        check("dw1.data0", 32'(bus1.data), 32'd1);
        check("dw1.start0", 32'(bus1.data_start), 32'd1);
        check("dw1.finish0", 32'(bus1.data_finish), 32'd1);
        check("dw1.busy0", 32'(bus1.busy), 32'd1);
        check("dw1.ready0", 32'(bus1.in_ready), 32'd1);
        tick();
        bus1.in_valid = 1'b0;
        check("dw1.data1", 32'(bus1.data), 32'd0);
        check("dw1.start1", 32'(bus1.data_start), 32'd1);
        check("dw1.finish1", 32'(bus1.data_finish), 32'd1);
        check("dw1.busy1", 32'(bus1.busy), 32'd1);
        tick();
        check("dw1.idle_start", 32'(bus1.data_start), 32'd0);
        check("dw1.idle_finish", 32'(bus1.data_finish), 32'd0);
        check("dw1.idle_busy", 32'(bus1.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
